// File: rtl/video_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// video_mode_ctrl_if
//
// Mode-request channel into video_mode_ctrl.
//
// Handshake: the master drives mode_valid/mode_sel, the slave drives
// mode_ready. A request transfers on a rising clk edge where mode_valid and
// mode_ready are both high. mode_sel must be stable whenever mode_valid is
// high. A master that sees mode_ready low keeps mode_valid and mode_sel
// asserted until the transfer happens. The slave keeps no queue, so a
// request that never sees mode_ready is simply dropped. mode_ready does not
// depend combinationally on mode_valid.
//
// Signals:
//   mode_valid  master -> slave  request present
//   mode_sel    master -> slave  requested mode index (0..3)
//   mode_ready  slave -> master  request can be accepted this cycle
// ---------------------------------------------------------------------------
interface video_mode_ctrl_if;
    logic       mode_valid;
    logic [1:0] mode_sel;
    logic       mode_ready;

    modport master (output mode_valid, output mode_sel, input mode_ready);
    modport slave  (input mode_valid, input mode_sel, output mode_ready);
endinterface

// File: rtl/video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// video_mode_ctrl
//
// Timing-mode sequencer for the progressive video sync generator that feeds
// the ADV7511. It holds four preset timings and drives the generator's
// timing inputs. A mode change is accepted over the request interface, then
// waits for a frame boundary (a rising edge of the generator's vsync, or a
// timeout). It then loads the new timing and holds the generator in reset
// for HOLD_CYCLES clocks before releasing it.
//
// Optional feature macro: VMODE_CUSTOM_EN. When it is defined, the cust_cfg
// input is added and mode 3 takes its timing from cust_cfg, captured when
// the request is accepted. A request for mode 3 always runs the full change
// sequence. When the macro is undefined, mode 3 is 800x600@60.
//
// Ports:
//   clk           pixel clock
//   reset         asynchronous, active-high reset
//   req           mode request channel (slave: mode_valid, mode_sel in;
//                 mode_ready out)
//   cust_cfg      custom timing, only with VMODE_CUSTOM_EN, packed MSB->LSB
//                 h_total,h_fp,h_sync,h_bp,v_total,v_fp,v_sync,v_bp
//   vs_in         vsync from the sync generator (active high)
//   sync_reset    reset to the sync generator
//   h_*/v_*       timing values for the generator's _0 and _1 inputs
//   hv_offset     vsync horizontal offset, always 0
//   cur_mode      mode currently applied
//   busy          high in any state other than RUN
//   mode_changed  one-cycle pulse when the generator is released with a new
//                 mode (no pulse on the release after reset)
//   timeout_flag  sticky: the last change was forced by timeout
//   state_dbg     current sequencer state (RUN=0, WAIT_VS=1, HOLD=2)
// ---------------------------------------------------------------------------
module video_mode_ctrl #(
    parameter int X_BITS         = 12,
    parameter int Y_BITS         = 12,
    parameter int DEFAULT_MODE   = 0,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4194304,
    parameter int TO_BITS        = 23
) (
    input  logic                           clk,
    input  logic                           reset,
    video_mode_ctrl_if.slave               req,
`ifdef VMODE_CUSTOM_EN
    input  logic [4*X_BITS+4*Y_BITS-1:0]   cust_cfg,
`endif
    input  logic                           vs_in,
    output logic                           sync_reset,
    output logic [X_BITS-1:0]              h_total,
    output logic [X_BITS-1:0]              h_fp,
    output logic [X_BITS-1:0]              h_bp,
    output logic [X_BITS-1:0]              h_sync,
    output logic [X_BITS-1:0]              hv_offset,
    output logic [Y_BITS-1:0]              v_total,
    output logic [Y_BITS-1:0]              v_fp,
    output logic [Y_BITS-1:0]              v_bp,
    output logic [Y_BITS-1:0]              v_sync,
    output logic [1:0]                     cur_mode,
    output logic                           busy,
    output logic                           mode_changed,
    output logic                           timeout_flag,
    output logic [1:0]                     state_dbg
);

    localparam int CFG_W = 4*X_BITS + 4*Y_BITS;
    localparam int HC_W  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [TO_BITS-1:0] TO_LAST   = TO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]         DEF_MODE  = 2'(DEFAULT_MODE);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Preset timing table. Fields are packed in the same order as cust_cfg.
    function automatic logic [CFG_W-1:0] preset_cfg(input logic [1:0] m);
        logic [CFG_W-1:0] c;
        case (m)
            2'd0: c = {X_BITS'(800),  X_BITS'(16),  X_BITS'(96),  X_BITS'(48),
                       Y_BITS'(525),  Y_BITS'(10),  Y_BITS'(2),   Y_BITS'(33)};
            2'd1: c = {X_BITS'(1650), X_BITS'(110), X_BITS'(40),  X_BITS'(220),
                       Y_BITS'(750),  Y_BITS'(5),   Y_BITS'(5),   Y_BITS'(20)};
            2'd2: c = {X_BITS'(2200), X_BITS'(88),  X_BITS'(44),  X_BITS'(148),
                       Y_BITS'(1125), Y_BITS'(4),   Y_BITS'(5),   Y_BITS'(36)};
            default: c = {X_BITS'(1056), X_BITS'(40), X_BITS'(128), X_BITS'(88),
                          Y_BITS'(628),  Y_BITS'(1),  Y_BITS'(4),   Y_BITS'(23)};
        endcase
        return c;
    endfunction

    state_t              state, state_n;
    logic [HC_W-1:0]     hold_cnt;
    logic [TO_BITS-1:0]  to_cnt;
    logic                vs_q;
    logic                vs_rise_q;
    logic [1:0]          pend_mode;
    logic [CFG_W-1:0]    pend_cfg;
    logic [CFG_W-1:0]    cfg_q;
    logic [1:0]          cur_mode_q;
    logic                sync_reset_q;
    logic                mode_ready_q;
    logic                busy_q;
    logic                mode_changed_q;
    logic                timeout_flag_q;
    logic                boot_q;       // set until the first release after reset

    logic                accept;
    logic                start_change;
    logic                force_to;
    logic                release_hold;
    logic                enter_hold;
    logic                is_change;
    logic [CFG_W-1:0]    req_cfg;

    // Timing to capture for the requested mode.
`ifdef VMODE_CUSTOM_EN
    assign req_cfg   = (req.mode_sel == 2'd3) ? cust_cfg : preset_cfg(req.mode_sel);
    // Mode 3 always reapplies so that edited custom values take effect.
    assign is_change = (req.mode_sel != cur_mode_q) || (req.mode_sel == 2'd3);
`else
    assign req_cfg   = preset_cfg(req.mode_sel);
    assign is_change = (req.mode_sel != cur_mode_q);
`endif

    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        start_change = 1'b0;
        force_to     = 1'b0;
        release_hold = 1'b0;
        case (state)
            ST_RUN: begin
                if (req.mode_valid && mode_ready_q) begin
                    accept = 1'b1;
                    if (is_change) begin
                        start_change = 1'b1;
                        state_n      = ST_WAIT_VS;
                    end
                end
            end
            ST_WAIT_VS: begin
                // A frame boundary takes priority over a timeout in the same cycle.
                if (vs_rise_q) begin
                    state_n = ST_HOLD;
                end else if (to_cnt == TO_LAST) begin
                    force_to = 1'b1;
                    state_n  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    release_hold = 1'b1;
                    state_n      = ST_RUN;
                end
            end
            default: state_n = ST_HOLD;
        endcase
    end

    assign enter_hold = (state == ST_WAIT_VS) && (state_n == ST_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_HOLD;
            hold_cnt       <= '0;
            to_cnt         <= '0;
            vs_q           <= 1'b0;
            vs_rise_q      <= 1'b0;
            pend_mode      <= DEF_MODE;
            pend_cfg       <= preset_cfg(DEF_MODE);
            cfg_q          <= preset_cfg(DEF_MODE);
            cur_mode_q     <= DEF_MODE;
            sync_reset_q   <= 1'b1;
            mode_ready_q   <= 1'b0;
            busy_q         <= 1'b1;
            mode_changed_q <= 1'b0;
            timeout_flag_q <= 1'b0;
            boot_q         <= 1'b1;
        end else begin
            state <= state_n;

            // The edge is registered, so HOLD begins two clocks after vs_in rises.
            vs_q      <= vs_in;
            vs_rise_q <= ~vs_q & vs_in;

            sync_reset_q   <= (state_n == ST_HOLD);
            mode_ready_q   <= (state_n == ST_RUN);
            busy_q         <= (state_n != ST_RUN);
            mode_changed_q <= release_hold & ~boot_q;
            if (release_hold) begin
                boot_q <= 1'b0;
            end

            if (accept) begin
                timeout_flag_q <= 1'b0;
            end else if (force_to) begin
                timeout_flag_q <= 1'b1;
            end

            if (start_change) begin
                pend_mode <= req.mode_sel;
                pend_cfg  <= req_cfg;
                to_cnt    <= '0;
            end else if (state == ST_WAIT_VS) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // Timing outputs only ever change on the HOLD entry edge.
            if (enter_hold) begin
                cfg_q      <= pend_cfg;
                cur_mode_q <= pend_mode;
                hold_cnt   <= '0;
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign {h_total, h_fp, h_sync, h_bp, v_total, v_fp, v_sync, v_bp} = cfg_q;
    assign hv_offset      = '0;
    assign cur_mode       = cur_mode_q;
    assign sync_reset     = sync_reset_q;
    assign busy           = busy_q;
    assign mode_changed   = mode_changed_q;
    assign timeout_flag   = timeout_flag_q;
    assign req.mode_ready = mode_ready_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_mode_ctrl
//
// Self-checking bench for video_mode_ctrl. It uses a short timeout (64) and
// HOLD_CYCLES=16. Inputs are driven and outputs sampled on the falling clock
// edge. The reference keeps the mode timing table and predicts when the
// hold starts:
//   - A vs_in rise driven k falling edges after acceptance starts the hold
//     at falling edge k+2.
//   - With no such rise, the hold starts at falling edge TIMEOUT.
//   - If both happen, the earlier one starts the hold, and the vsync rise
//     wins a tie.
// Each mode_changed pulse is matched against a queue of expected modes.
// ---------------------------------------------------------------------------
module tb_video_mode_ctrl;
    localparam int XB   = 12;
    localparam int YB   = 12;
    localparam int HOLD = 16;
    localparam int TOC  = 64;
    localparam int TOB  = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vs_in = 1'b0;
    logic          sync_reset;
    logic [XB-1:0] h_total, h_fp, h_bp, h_sync, hv_offset;
    logic [YB-1:0] v_total, v_fp, v_bp, v_sync;
    logic [1:0]    cur_mode;
    logic          busy, mode_changed, timeout_flag;
    logic [1:0]    state_dbg;

    video_mode_ctrl_if req_if();

`ifdef VMODE_CUSTOM_EN
    // Start equal to the 800x600 entry so mode 3 matches the reference table.
    logic [4*XB+4*YB-1:0] cust_cfg = {XB'(1056), XB'(40), XB'(128), XB'(88),
                                      YB'(628), YB'(1), YB'(4), YB'(23)};
`endif

    video_mode_ctrl #(
        .X_BITS(XB), .Y_BITS(YB), .DEFAULT_MODE(0), .HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TOC), .TO_BITS(TOB)
    ) dut (
        .clk(clk), .reset(reset), .req(req_if),
`ifdef VMODE_CUSTOM_EN
        .cust_cfg(cust_cfg),
`endif
        .vs_in(vs_in), .sync_reset(sync_reset),
        .h_total(h_total), .h_fp(h_fp), .h_bp(h_bp), .h_sync(h_sync),
        .hv_offset(hv_offset),
        .v_total(v_total), .v_fp(v_fp), .v_bp(v_bp), .v_sync(v_sync),
        .cur_mode(cur_mode), .busy(busy), .mode_changed(mode_changed),
        .timeout_flag(timeout_flag), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference state ----------------
    int         n_checks = 0;
    int         n_fail = 0;
    int         ref_tab[4][8];     // h_total,h_fp,h_sync,h_bp,v_total,v_fp,v_sync,v_bp
    int         model_mode = 0;
    int         model_flag = 0;
    logic [1:0] exp_q[$];          // modes expected at each mode_changed pulse

    typedef struct {
        int mode;
        int vs_j;       // falling edge (after acceptance) at which vs_in rises; -1 = never
        int exp_start;  // falling edge at which sync_reset is first seen high; -1 = no change
        int exp_flag;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_start(input int vs_j);
        int e;
        e = (vs_j >= 0) ? vs_j + 2 : TOC + 1;
        return (e <= TOC) ? e : TOC;
    endfunction

    function automatic int model_to_flag(input int vs_j);
        return (vs_j < 0 || vs_j + 2 > TOC) ? 1 : 0;
    endfunction

    function automatic bit model_is_change(input int m);
`ifdef VMODE_CUSTOM_EN
        return (m != model_mode) || (m == 3);
`else
        return (m != model_mode);
`endif
    endfunction

    task automatic chk_cfg(input string tag, input int m);
        chk({tag, " h_total"}, int'(h_total), ref_tab[m][0]);
        chk({tag, " h_fp"},    int'(h_fp),    ref_tab[m][1]);
        chk({tag, " h_sync"},  int'(h_sync),  ref_tab[m][2]);
        chk({tag, " h_bp"},    int'(h_bp),    ref_tab[m][3]);
        chk({tag, " v_total"}, int'(v_total), ref_tab[m][4]);
        chk({tag, " v_fp"},    int'(v_fp),    ref_tab[m][5]);
        chk({tag, " v_sync"},  int'(v_sync),  ref_tab[m][6]);
        chk({tag, " v_bp"},    int'(v_bp),    ref_tab[m][7]);
        chk({tag, " hv_offset"}, int'(hv_offset), 0);
        chk({tag, " cur_mode"},  int'(cur_mode),  m);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset && mode_changed) begin
            if (exp_q.size() == 0) begin
                chk("unexpected mode_changed pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse cur_mode", int'(cur_mode), int'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called on the falling edge where reset has just been released.
    task automatic check_boot(input string tag);
        int highs;
        highs = 0;
        while (sync_reset && highs < 100) begin
            highs++;
            @(negedge clk);
        end
        chk({tag, " boot hold length"}, highs, HOLD);
        chk({tag, " busy after boot"}, int'(busy), 0);
        chk({tag, " ready after boot"}, int'(req_if.mode_ready), 1);
        chk({tag, " no pulse at boot"}, int'(mode_changed), 0);
        chk({tag, " flag after boot"}, int'(timeout_flag), 0);
        chk_cfg({tag, " boot"}, 0);
        @(negedge clk);
        chk({tag, " no pulse after boot"}, int'(mode_changed), 0);
    endtask

    task automatic do_req(input string tag, input int m, input int vs_j,
                          input int exp_start, input int exp_flag);
        int hold_at, prev_h, prev_v, highs;
        @(negedge clk);
        chk({tag, " ready before"}, int'(req_if.mode_ready), 1);
        chk({tag, " flag before"}, int'(timeout_flag), model_flag);
        req_if.mode_valid = 1'b1;
        req_if.mode_sel   = 2'(m);
        @(negedge clk);   // acceptance edge has passed: falling edge 0
        req_if.mode_valid = 1'b0;
        chk({tag, " flag cleared on accept"}, int'(timeout_flag), 0);
        model_flag = 0;
        if (exp_start < 0) begin
            chk({tag, " same: ready"}, int'(req_if.mode_ready), 1);
            chk({tag, " same: busy"}, int'(busy), 0);
            repeat (3) @(negedge clk);
            chk({tag, " same: sync_reset"}, int'(sync_reset), 0);
            chk({tag, " same: busy later"}, int'(busy), 0);
            chk_cfg({tag, " same"}, model_mode);
            return;
        end
        chk({tag, " ready low after accept"}, int'(req_if.mode_ready), 0);
        chk({tag, " busy after accept"}, int'(busy), 1);
        exp_q.push_back(2'(m));
        hold_at = -1;
        prev_h  = int'(h_total);
        prev_v  = int'(v_total);
        for (int k = 0; k < 200; k++) begin
            if (sync_reset) begin
                hold_at = k;
                break;
            end
            prev_h = int'(h_total);
            prev_v = int'(v_total);
            if (k == vs_j) vs_in = 1'b1;
            else if (k == vs_j + 3) vs_in = 1'b0;
            @(negedge clk);
        end
        vs_in = 1'b0;
        chk({tag, " hold start"}, hold_at, exp_start);
        chk({tag, " old h_total before hold"}, prev_h, ref_tab[model_mode][0]);
        chk({tag, " old v_total before hold"}, prev_v, ref_tab[model_mode][4]);
        chk({tag, " timeout_flag"}, int'(timeout_flag), exp_flag);
        model_flag = exp_flag;
        chk_cfg({tag, " hold entry"}, m);
        highs = 0;
        while (sync_reset && highs < 100) begin
            highs++;
            @(negedge clk);
        end
        chk({tag, " hold length"}, highs, HOLD);
        chk({tag, " pulse at release"}, int'(mode_changed), 1);
        chk({tag, " ready at release"}, int'(req_if.mode_ready), 1);
        chk({tag, " busy at release"}, int'(busy), 0);
        @(negedge clk);
        chk({tag, " pulse one cycle"}, int'(mode_changed), 0);
        chk({tag, " flag sticky"}, int'(timeout_flag), exp_flag);
        model_mode = m;
        chk_cfg({tag, " running"}, m);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[8];

    initial begin
        int m, vs_j, es, ef, target, waited;

        ref_tab[0] = '{800, 16, 96, 48, 525, 10, 2, 33};
        ref_tab[1] = '{1650, 110, 40, 220, 750, 5, 5, 20};
        ref_tab[2] = '{2200, 88, 44, 148, 1125, 4, 5, 36};
        ref_tab[3] = '{1056, 40, 128, 88, 628, 1, 4, 23};

        vecs[0] = '{2, 40, 42, -0};    // vsync edge 40 cycles in
        vecs[1] = '{2, 5, -1, 0};      // same mode
        vecs[2] = '{1, -1, 64, 1};     // no vsync: timeout
        vecs[3] = '{1, 10, -1, 0};     // same mode clears the sticky flag
        vecs[4] = '{3, 62, 64, 0};     // vsync and timeout together: vsync wins
        vecs[5] = '{0, 63, 64, 1};     // vsync one cycle too late
        vecs[6] = '{2, 0, 2, 0};       // vsync immediately
        vecs[7] = '{0, 100, 64, 1};    // vsync far beyond timeout

        req_if.mode_valid = 1'b0;
        req_if.mode_sel   = 2'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset sync_reset", int'(sync_reset), 1);
        chk("reset mode_ready", int'(req_if.mode_ready), 0);
        chk("reset busy", int'(busy), 1);
        chk("reset mode_changed", int'(mode_changed), 0);
        chk("reset timeout_flag", int'(timeout_flag), 0);
        chk_cfg("reset", 0);
        reset = 1'b0;
        check_boot("boot");

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].mode, vecs[i].vs_j,
                   vecs[i].exp_start, vecs[i].exp_flag);
        end

        // Reset asserted while HOLD is loading a new mode.
        target = (model_mode == 1) ? 2 : 1;
        @(negedge clk);
        req_if.mode_valid = 1'b1;
        req_if.mode_sel   = 2'(target);
        @(negedge clk);
        req_if.mode_valid = 1'b0;
        vs_in = 1'b1;
        waited = 0;
        while (!sync_reset && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        vs_in = 1'b0;
        chk("midhold reached hold", int'(sync_reset), 1);
        repeat (3) @(negedge clk);
        chk("midhold loaded cur_mode", int'(cur_mode), target);
        reset = 1'b1;
        #1;
        chk("midhold reset sync_reset", int'(sync_reset), 1);
        chk("midhold reset busy", int'(busy), 1);
        chk("midhold reset ready", int'(req_if.mode_ready), 0);
        chk("midhold reset flag", int'(timeout_flag), 0);
        chk_cfg("midhold reset", 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_mode = 0;
        model_flag = 0;
        check_boot("reboot");

        // Randomized requests against the reference.
        for (int i = 0; i < 20; i++) begin
            m    = int'($urandom_range(0, 3));
            vs_j = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
            if (model_is_change(m)) begin
                es = model_start(vs_j);
                ef = model_to_flag(vs_j);
            end else begin
                es = -1;
                ef = 0;
            end
            do_req($sformatf("rnd%0d", i), m, vs_j, es, ef);
        end

`ifdef VMODE_CUSTOM_EN
        // Custom timing: captured at acceptance, reapplied on every mode 3 request.
        cust_cfg = {XB'(1000), XB'(20), XB'(30), XB'(50), YB'(600), YB'(3), YB'(4), YB'(10)};
        ref_tab[3] = '{1000, 20, 30, 50, 600, 3, 4, 10};
        do_req("cust1", 3, 5, 7, 0);
        cust_cfg = {XB'(1100), XB'(22), XB'(33), XB'(55), YB'(650), YB'(4), YB'(5), YB'(12)};
        ref_tab[3] = '{1100, 22, 33, 55, 650, 4, 5, 12};
        do_req("cust2", 3, 5, 7, 0);
`endif

        repeat (3) @(negedge clk);
        chk("all expected pulses seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
